// File: rtl/ocx_dlx_xlx_if_gen.sv
// DLx / GT-wizard glue logic.
// Waits for sync on every enabled lane, pulses the PHY RX-datapath reset and then
// waits for RX ready. A timed-out wait re-pulses, up to a bounded number of times,
// before parking in a sticky failure state. Also debounces card detect into the PHY
// full reset and gates the DLx reset according to send_first.
module ocx_dlx_xlx_if_gen #(
  parameter int LANES           = 8,
  parameter int PULSE_CYCLES    = 8,
  parameter int RETRAIN_TIMEOUT = 1024,
  parameter int MAX_RETRAINS    = 7,
  parameter int DEBOUNCE_DEPTH  = 5
) (
  input  logic             opt_gckn,
  input  logic             reset,
  input  logic             ocde,
  input  logic             send_first,
  input  logic [LANES-1:0] lane_enable,
  input  logic [LANES-1:0] pb_io_o0_rx_run_lane,
  input  logic             gtwiz_reset_tx_done_in,
  input  logic             gtwiz_buffbypass_tx_done_in,
  input  logic             gtwiz_reset_rx_done_in,
  input  logic             gtwiz_buffbypass_rx_done_in,
  input  logic             gtwiz_userclk_rx_active_in,
  input  logic [LANES-1:0] ln_rx_valid_in,
  output logic             gtwiz_reset_all_out,
  output logic             gtwiz_reset_rx_datapath_out,
  output logic             dlx_reset,
  output logic [LANES-1:0] io_pb_o0_rx_init_done,
  output logic [LANES-1:0] ln_rx_valid_out,
  output logic [7:0]       retrain_count,
  output logic             retrain_fail
);

  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int TW = $clog2(RETRAIN_TIMEOUT);
  localparam logic [PW-1:0] PULSE_LAST  = PW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(RETRAIN_TIMEOUT - 1);
  localparam logic [7:0]    RETRAIN_MAX = 8'(MAX_RETRAINS);

  typedef enum logic [2:0] {
    S_FIND_SYNC  = 3'd0,
    S_HOLD_PULSE = 3'd1,
    S_WAIT_RX    = 3'd2,
    S_PULSE_DONE = 3'd3,
    S_FAIL       = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [PW-1:0]             r_pulse_cnt;
  logic [PW-1:0]             w_pulse_cnt_nxt;
  logic [TW-1:0]             r_tmo_cnt;
  logic [TW-1:0]             w_tmo_cnt_nxt;
  logic [7:0]                r_retrain;
  logic [7:0]                w_retrain_nxt;
  logic                      r_fail;
  logic [DEBOUNCE_DEPTH-1:0] r_db;
  logic                      r_all_out;
  logic                      r_rx_first;

  logic w_tx_ok;
  logic w_rx_ok;
  logic w_rx_rdy;
  logic w_tx_down;
  logic w_sync_all;
  logic w_all_rise;
  logic w_all_fall;

  assign w_tx_ok    = gtwiz_reset_tx_done_in & gtwiz_buffbypass_tx_done_in;
  assign w_rx_ok    = gtwiz_reset_rx_done_in & gtwiz_buffbypass_rx_done_in;
  assign w_rx_rdy   = w_rx_ok & gtwiz_userclk_rx_active_in;
  assign w_tx_down  = ~gtwiz_reset_tx_done_in & ~gtwiz_buffbypass_tx_done_in;
  // Disabled lanes count as synced; an all-disabled mask never counts as sync.
  assign w_sync_all = (lane_enable != '0) & (&(pb_io_o0_rx_run_lane | ~lane_enable));
  // The full-reset output only moves once the whole history window agrees.
  assign w_all_fall = (&r_db) & r_all_out;
  assign w_all_rise = (~|r_db) & ~r_all_out;

  // Next-state and counter updates for the sync / pulse / retrain sequence.
  always_comb begin
    w_state_nxt     = r_state;
    w_pulse_cnt_nxt = r_pulse_cnt;
    w_tmo_cnt_nxt   = r_tmo_cnt;
    w_retrain_nxt   = r_retrain;
    case (r_state)
      S_FIND_SYNC: begin
        if (w_sync_all) begin
          w_state_nxt     = S_HOLD_PULSE;
          w_pulse_cnt_nxt = '0;
        end
      end
      S_HOLD_PULSE: begin
        if (r_pulse_cnt == PULSE_LAST) begin
          w_state_nxt   = S_WAIT_RX;
          w_tmo_cnt_nxt = '0;
        end else begin
          w_pulse_cnt_nxt = r_pulse_cnt + 1'b1;
        end
      end
      S_WAIT_RX: begin
        // RX ready wins over a timeout landing on the same cycle.
        if (w_rx_rdy) begin
          w_state_nxt = S_PULSE_DONE;
        end else if (r_tmo_cnt == TMO_LAST) begin
          if (r_retrain == RETRAIN_MAX) begin
            w_state_nxt = S_FAIL;
          end else begin
            w_retrain_nxt   = r_retrain + 8'd1;
            w_state_nxt     = S_HOLD_PULSE;
            w_pulse_cnt_nxt = '0;
          end
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
        end
      end
      S_PULSE_DONE: begin
        if (w_tx_down) begin
          w_state_nxt   = S_FIND_SYNC;
          w_retrain_nxt = '0;
        end
      end
      S_FAIL: begin
        // Leave on the same edge the debounced full reset rises.
        if (w_all_rise) begin
          w_state_nxt   = S_FIND_SYNC;
          w_retrain_nxt = '0;
        end
      end
      default: w_state_nxt = S_FIND_SYNC;
    endcase
  end

  // State, counters and sticky failure flag.
  always_ff @(posedge opt_gckn) begin
    if (reset) begin
      r_state     <= S_FIND_SYNC;
      r_pulse_cnt <= '0;
      r_tmo_cnt   <= '0;
      r_retrain   <= '0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pulse_cnt <= w_pulse_cnt_nxt;
      r_tmo_cnt   <= w_tmo_cnt_nxt;
      r_retrain   <= w_retrain_nxt;
      r_fail      <= (w_state_nxt == S_FAIL);
    end
  end

  // Card-detect debounce: shift history and toggle the full reset on unanimity.
  always_ff @(posedge opt_gckn) begin
    if (reset) begin
      r_db      <= '0;
      r_all_out <= 1'b1;
    end else begin
      r_db <= {r_db[DEBOUNCE_DEPTH-2:0], ocde};
      if (w_all_fall) begin
        r_all_out <= 1'b0;
      end else if (w_all_rise) begin
        r_all_out <= 1'b1;
      end
    end
  end

  // Receive-first flag: set once RX comes up, cleared when both TX dones drop.
  always_ff @(posedge opt_gckn) begin
    if (reset) begin
      r_rx_first <= 1'b0;
    end else if (!r_rx_first) begin
      if (w_rx_ok) r_rx_first <= 1'b1;
    end else if (w_tx_down) begin
      r_rx_first <= 1'b0;
    end
  end

  assign gtwiz_reset_all_out         = r_all_out;
  assign gtwiz_reset_rx_datapath_out = ~reset & (r_state == S_HOLD_PULSE);
  assign io_pb_o0_rx_init_done       = (~reset & (r_state == S_PULSE_DONE) & w_rx_rdy) ?
                                       lane_enable : '0;
  assign dlx_reset                   = reset ? 1'b1 :
                                       send_first ? ~w_tx_ok :
                                       r_rx_first ? 1'b0 : ~w_rx_ok;
  assign ln_rx_valid_out             = ln_rx_valid_in & lane_enable & {LANES{w_rx_ok}};
  assign retrain_count               = r_retrain;
  assign retrain_fail                = r_fail;

endmodule

// File: tb/tb_ocx_dlx_xlx_if_gen.sv
// Bench for ocx_dlx_xlx_if_gen: directed scenarios followed by random traffic,
// every cycle compared against a phase-based behavioural model.
module tb_ocx_dlx_xlx_if_gen;

  localparam int L  = 8;
  localparam int PC = 8;
  localparam int RT = 16;
  localparam int MR = 2;
  localparam int DD = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         ocde;
  logic         sf;
  logic [L-1:0] en;
  logic [L-1:0] run;
  logic         txd;
  logic         txbb;
  logic         rxd;
  logic         rxbb;
  logic         act;
  logic [L-1:0] vin;

  logic         all_out;
  logic         dp;
  logic         dlx;
  logic [L-1:0] init;
  logic [L-1:0] vout;
  logic [7:0]   cnt;
  logic         fail;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: named phase, countdown of pulse cycles, cycles waited,
  // retrain tally, and a window of recent card-detect samples.
  string m_ph = "SYNC";
  int    m_pulse_left;
  int    m_waited;
  int    m_retr;
  bit    m_fail;
  bit    m_all;
  bit    m_rxfirst;
  bit    hist[$];

  ocx_dlx_xlx_if_gen #(
    .LANES(L), .PULSE_CYCLES(PC), .RETRAIN_TIMEOUT(RT),
    .MAX_RETRAINS(MR), .DEBOUNCE_DEPTH(DD)
  ) dut (
    .opt_gckn                    (clk),
    .reset                       (rst),
    .ocde                        (ocde),
    .send_first                  (sf),
    .lane_enable                 (en),
    .pb_io_o0_rx_run_lane        (run),
    .gtwiz_reset_tx_done_in      (txd),
    .gtwiz_buffbypass_tx_done_in (txbb),
    .gtwiz_reset_rx_done_in      (rxd),
    .gtwiz_buffbypass_rx_done_in (rxbb),
    .gtwiz_userclk_rx_active_in  (act),
    .ln_rx_valid_in              (vin),
    .gtwiz_reset_all_out         (all_out),
    .gtwiz_reset_rx_datapath_out (dp),
    .dlx_reset                   (dlx),
    .io_pb_o0_rx_init_done       (init),
    .ln_rx_valid_out             (vout),
    .retrain_count               (cnt),
    .retrain_fail                (fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    bit           rx_ok;
    bit           tx_ok;
    bit           rdy;
    logic [L-1:0] e_init;
    logic [L-1:0] e_vld;
    bit           e_dlx;
    rx_ok  = rxd && rxbb;
    tx_ok  = txd && txbb;
    rdy    = rx_ok && act;
    e_init = (!rst && m_ph == "DONE" && rdy) ? en : '0;
    e_vld  = rx_ok ? (vin & en) : '0;
    if (rst)          e_dlx = 1'b1;
    else if (sf)      e_dlx = !tx_ok;
    else if (m_rxfirst) e_dlx = 1'b0;
    else              e_dlx = !rx_ok;
    chk("m_datapath", 32'(dp), 32'(!rst && m_ph == "PULSE"));
    chk("m_init_done", 32'(init), 32'(e_init));
    chk("m_dlx_reset", 32'(dlx), 32'(e_dlx));
    chk("m_rx_valid", 32'(vout), 32'(e_vld));
    chk("m_reset_all", 32'(all_out), 32'(m_all));
    chk("m_retrain_count", 32'(cnt), 32'(m_retr));
    chk("m_retrain_fail", 32'(fail), 32'(m_fail));
  endtask

  task automatic model_update();
    int  s;
    bit  ones;
    bit  zeros;
    bit  rise;
    bit  rx_ok;
    bit  tx_down;
    bit  synced;
    if (rst) begin
      m_ph = "SYNC"; m_pulse_left = 0; m_waited = 0; m_retr = 0;
      m_fail = 1'b0; m_all = 1'b1; m_rxfirst = 1'b0;
      hist.delete();
      repeat (DD) hist.push_back(1'b0);
      return;
    end
    s = 0;
    foreach (hist[i]) s += int'(hist[i]);
    ones    = (s == DD);
    zeros   = (s == 0);
    rise    = zeros && !m_all;
    rx_ok   = rxd && rxbb;
    tx_down = !txd && !txbb;
    synced  = (en != 0) && ((run & en) == en);
    if (m_ph == "SYNC") begin
      if (synced) begin m_ph = "PULSE"; m_pulse_left = PC; end
    end else if (m_ph == "PULSE") begin
      m_pulse_left--;
      if (m_pulse_left == 0) begin m_ph = "WAIT"; m_waited = 0; end
    end else if (m_ph == "WAIT") begin
      m_waited++;
      if (rx_ok && act) m_ph = "DONE";
      else if (m_waited == RT) begin
        if (m_retr == MR) begin m_ph = "FAIL"; m_fail = 1'b1; end
        else begin m_retr++; m_ph = "PULSE"; m_pulse_left = PC; end
      end
    end else if (m_ph == "DONE") begin
      if (tx_down) begin m_ph = "SYNC"; m_retr = 0; end
    end else if (m_ph == "FAIL") begin
      if (rise) begin m_ph = "SYNC"; m_retr = 0; m_fail = 1'b0; end
    end
    if (ones && m_all) m_all = 1'b0;
    else if (rise) m_all = 1'b1;
    hist.push_back(ocde);
    void'(hist.pop_front());
    if (!m_rxfirst) begin
      if (rx_ok) m_rxfirst = 1'b1;
    end else if (tx_down) begin
      m_rxfirst = 1'b0;
    end
  endtask

  // One clock: compare at the falling edge, advance the model on the rising edge.
  task automatic cyc();
    @(negedge clk);
    if (chk_en) model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    int n;
    int pulses;
    int cycles;
    bit prev;

    rst = 1'b1; ocde = 1'b1; sf = 1'b1; en = '0; run = '0;
    txd = 1'b0; txbb = 1'b0; rxd = 1'b0; rxbb = 1'b0; act = 1'b0; vin = '0;
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("rst_datapath", 32'(dp), 32'd0);
    chk("rst_dlx", 32'(dlx), 32'd1);
    chk("rst_reset_all", 32'(all_out), 32'd1);
    chk("rst_init_done", 32'(init), 32'd0);
    chk("rst_count", 32'(cnt), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);

    // Debounce: five high samples, output falls on the sixth edge; short glitch ignored.
    rst = 1'b0;
    repeat (5) cyc();
    chk("deb_hold5", 32'(all_out), 32'd1);
    cyc();
    chk("deb_fall6", 32'(all_out), 32'd0);
    ocde = 1'b0;
    repeat (3) cyc();
    ocde = 1'b1;
    repeat (6) cyc();
    chk("deb_glitch", 32'(all_out), 32'd0);

    // Sync on lanes 3:0, pulse width, then RX ready.
    txd = 1'b1; txbb = 1'b1; en = 8'h0F; run = 8'h0F;
    cyc();
    n = 0;
    while (dp && n < 40) begin n++; cyc(); end
    chk("pulse_width", 32'(n), 32'(PC));
    rxd = 1'b1; rxbb = 1'b1; act = 1'b1; vin = 8'hF3;
    #1;
    chk("valid_mask", 32'(vout), 32'h03);
    cyc();
    chk("init_done", 32'(init), 32'h0F);
    txd = 1'b0; txbb = 1'b0; run = '0; rxd = 1'b0; rxbb = 1'b0; act = 1'b0;
    cyc();
    chk("done_exit_dp", 32'(dp), 32'd0);
    chk("done_exit_init", 32'(init), 32'd0);

    // Retrain exhaustion into FAIL, then recovery via card-detect cycling.
    txd = 1'b1; txbb = 1'b1; run = 8'h0F;
    cyc();
    pulses = 0; cycles = 0; prev = 1'b0;
    while (!fail && cycles < 500) begin
      if (dp && !prev) pulses++;
      prev = dp;
      cyc();
      cycles++;
    end
    chk("retrain_pulses", 32'(pulses), 32'(MR + 1));
    chk("retrain_cycles", 32'(cycles), 32'(3 * (PC + RT)));
    chk("retrain_cnt", 32'(cnt), 32'(MR));
    repeat (3) cyc();
    chk("fail_no_pulse", 32'(dp), 32'd0);
    chk("fail_sticky", 32'(fail), 32'd1);
    ocde = 1'b0;
    n = 0;
    while (fail && n < 50) begin cyc(); n++; end
    chk("fail_exit_cycles", 32'(n), 32'(DD + 1));
    chk("fail_exit_all", 32'(all_out), 32'd1);
    chk("fail_exit_cnt", 32'(cnt), 32'd0);

    // RX ready on the exact timeout cycle of a retrain wins.
    ocde = 1'b1;
    cyc();
    n = 0;
    while (dp && n < 40) begin cyc(); n++; end
    repeat (RT) cyc();
    chk("tmo_repulse", 32'(dp), 32'd1);
    chk("tmo_cnt1", 32'(cnt), 32'd1);
    n = 0;
    while (dp && n < 40) begin cyc(); n++; end
    repeat (RT - 1) cyc();
    rxd = 1'b1; rxbb = 1'b1; act = 1'b1;
    cyc();
    chk("tmo_tie_init", 32'(init), 32'h0F);
    chk("tmo_tie_cnt", 32'(cnt), 32'd1);
    chk("tmo_tie_dp", 32'(dp), 32'd0);

    // dlx_reset gating with send_first = 0.
    run = '0; txd = 1'b0; txbb = 1'b0; rxd = 1'b0; rxbb = 1'b0; act = 1'b0;
    cyc();
    sf = 1'b0; txd = 1'b1; txbb = 1'b1;
    #1; chk("dlx_wait_rx", 32'(dlx), 32'd1);
    rxd = 1'b1; rxbb = 1'b1;
    #1; chk("dlx_rx_up", 32'(dlx), 32'd0);
    cyc();
    rxd = 1'b0;
    #1; chk("dlx_rx_drop", 32'(dlx), 32'd0);
    cyc();
    chk("dlx_flag_hold", 32'(dlx), 32'd0);
    txd = 1'b0; txbb = 1'b0;
    cyc();
    chk("dlx_flag_clear", 32'(dlx), 32'd1);
    sf = 1'b1; txd = 1'b1; txbb = 1'b1;
    #1; chk("dlx_send_first", 32'(dlx), 32'd0);

    // Reset in the middle of a pulse.
    rxd = 1'b0; rxbb = 1'b0; run = 8'h0F;
    cyc();
    cyc();
    cyc();
    chk("mid_pulse_high", 32'(dp), 32'd1);
    rst = 1'b1;
    cyc();
    chk("mid_rst_dp", 32'(dp), 32'd0);
    chk("mid_rst_dlx", 32'(dlx), 32'd1);
    chk("mid_rst_all", 32'(all_out), 32'd1);
    chk("mid_rst_cnt", 32'(cnt), 32'd0);
    rst = 1'b0;

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) ocde = ~ocde;
      if ($urandom_range(0, 199) == 0) sf = ~sf;
      if ($urandom_range(0, 99) == 0) en = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      run = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (en | 8'($urandom));
      if ($urandom_range(0, 29) == 0) txd = ~txd;
      if ($urandom_range(0, 29) == 0) txbb = ~txbb;
      if ($urandom_range(0, 19) == 0) rxd = ~rxd;
      if ($urandom_range(0, 19) == 0) rxbb = ~rxbb;
      if ($urandom_range(0, 19) == 0) act = ~act;
      vin = 8'($urandom);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ocx_dlx_xlx_if_gen.md
Name: ocx_dlx_xlx_if_gen

Overview:
Parametrised successor to the DLx/Xilinx-PHY glue logic, sitting between the DLx training logic and the GT wizard.
- Detects sync on all enabled lanes, pulses the PHY RX-datapath reset for a programmable width, then waits for RX ready.
- Adds a bounded, timed-out retrain loop with a sticky failure flag, per-lane enable masking and a parametrised ocde debounce.
- Gates DLx reset according to send_first.

Parameters:
LANES, 8, number of lanes (1..16)
PULSE_CYCLES, 8, cycles gtwiz_reset_rx_datapath_out is held high per pulse (>=1)
RETRAIN_TIMEOUT, 1024, cycles to wait in WAIT_RX for RX ready before re-pulsing (>=2)
MAX_RETRAINS, 7, re-pulses allowed before FAIL (0..255)
DEBOUNCE_DEPTH, 5, consecutive equal ocde samples needed to change gtwiz_reset_all_out (>=2)

Ports:
opt_gckn  in  1  sole clock, RX-domain clock
reset  in  1  synchronous, active-high reset
ocde  in  1  raw card-detect; low requests PHY reset
send_first  in  1  1 = transmit after TX ready; 0 = wait for RX ready first
lane_enable  in  LANES  lanes participating in sync/init
pb_io_o0_rx_run_lane  in  LANES  per-lane sync-detected from DLx
gtwiz_reset_tx_done_in  in  1  PHY TX reset done
gtwiz_buffbypass_tx_done_in  in  1  PHY TX buffer-bypass done
gtwiz_reset_rx_done_in  in  1  PHY RX reset done
gtwiz_buffbypass_rx_done_in  in  1  PHY RX buffer-bypass done
gtwiz_userclk_rx_active_in  in  1  RX user clock active
ln_rx_valid_in  in  LANES  per-lane PHY RX valid
gtwiz_reset_all_out  out  1  debounced PHY full reset
gtwiz_reset_rx_datapath_out  out  1  RX datapath reset pulse
dlx_reset  out  1  DLx reset
io_pb_o0_rx_init_done  out  LANES  per-lane RX init done to DLx
ln_rx_valid_out  out  LANES  masked RX valid
retrain_count  out  8  re-pulses in current attempt
retrain_fail  out  1  sticky retrain failure

Behaviour:
- Definitions:
  - tx_ok = gtwiz_reset_tx_done_in & gtwiz_buffbypass_tx_done_in.
  - rx_ok = gtwiz_reset_rx_done_in & gtwiz_buffbypass_rx_done_in.
  - sync_all = (lane_enable != 0) & &(pb_io_o0_rx_run_lane | ~lane_enable).
- Reset values:
  - State FIND_SYNC; pulse counter, timeout counter and retrain_count = 0.
  - retrain_fail = 0; debounce shift register all 0; gtwiz_reset_all_out = 1; rec_first flag = 0.
  - gtwiz_reset_rx_datapath_out = 0, io_pb_o0_rx_init_done = 0, dlx_reset = 1 (all forced while reset is high).
- FIND_SYNC:
  - sync_all -> HOLD_PULSE, pulse counter cleared.
- HOLD_PULSE:
  - datapath_out = 1; pulse counter increments.
  - At count PULSE_CYCLES-1 -> WAIT_RX, timeout counter cleared. The output is high for exactly PULSE_CYCLES cycles.
- WAIT_RX:
  - timeout counter increments.
  - rx_ok & gtwiz_userclk_rx_active_in -> PULSE_DONE. This has priority over a timeout in the same cycle.
  - Else at count RETRAIN_TIMEOUT-1:
    - retrain_count == MAX_RETRAINS -> FAIL.
    - Otherwise retrain_count += 1 -> HOLD_PULSE.
- PULSE_DONE:
  - io_pb_o0_rx_init_done = lane_enable & {LANES{rx_ok & gtwiz_userclk_rx_active_in}}; 0 in every other state.
  - ~gtwiz_reset_tx_done_in & ~gtwiz_buffbypass_tx_done_in -> FIND_SYNC, retrain_count cleared.
- FAIL:
  - retrain_fail = 1; no pulses issued.
  - Exit only on reset, or on the cycle gtwiz_reset_all_out rises -> FIND_SYNC. retrain_fail and retrain_count clear on that exit.
- Undefined state encodings -> FIND_SYNC.
- Counter widths: sized with clog2 of their terminal value; counters never wrap (terminal transitions occur first).
- Debounce:
  - ocde shifts into a DEBOUNCE_DEPTH register each cycle.
  - All ones and gtwiz_reset_all_out = 1 -> out goes 0 next cycle.
  - All zeros and out = 0 -> out goes 1.
  - Otherwise hold. A single glitch sample never toggles the output.
- Receive-first flag:
  - 0 -> 1 when rx_ok.
  - 1 -> 0 when ~gtwiz_reset_tx_done_in & ~gtwiz_buffbypass_tx_done_in.
- dlx_reset (combinational, forced 1 during reset):
  - send_first = 1: ~tx_ok.
  - send_first = 0, flag = 0: ~rx_ok.
  - send_first = 0, flag = 1: 0.
- ln_rx_valid_out = ln_rx_valid_in & lane_enable & {LANES{rx_ok}}, combinational, zero latency.
- Reset mid-operation: takes effect on the next edge; a pulse in progress is truncated.
- Changes to lane_enable are sampled every cycle; they affect only FIND_SYNC entry and output masks.

Test Plan:
1. Release reset, ocde=1 for 5 cycles -> gtwiz_reset_all_out falls on cycle 6. Then a 3-cycle ocde=0 glitch -> output stays 0.
2. LANES=8, lane_enable=8'h0F, run_lane=8'h0F -> datapath_out high exactly 8 cycles. Then rx_ok and rx_active -> init_done=8'h0F; ln_rx_valid_out masks lanes 7:4.
3. Sync, rx_ok held low, RETRAIN_TIMEOUT=16, MAX_RETRAINS=2 -> two extra pulses, retrain_count=2, then FAIL with retrain_fail=1. Cycling ocde low then high -> return to FIND_SYNC with retrain_count=0.
4. rx_ok asserted on the exact timeout cycle -> PULSE_DONE, retrain_count unchanged.
5. send_first=0, tx_ok=1, rx_ok=0 -> dlx_reset=1. rx_ok rises -> dlx_reset falls and stays 0 after rx_ok drops. Both tx-done inputs drop -> dlx_reset returns to ~rx_ok.
6. Assert reset during HOLD_PULSE cycle 3 -> next cycle datapath_out=0, state FIND_SYNC, dlx_reset=1, gtwiz_reset_all_out=1.
